// File: rtl/lsu_pkg.sv
// Shared RV32I load/store definitions: width codes, FSM states, byte-enable
// patterns and the access legality / lane helpers used by the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unsigned widths are load-only; halfwords and words must be naturally aligned.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr_lo[0];
      F3_W:    f = (addr_lo != 2'b00);
      F3_BU:   f = is_store;
      F3_HU:   f = is_store | addr_lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] byte_enables(input logic       is_store,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    if (!is_store) begin
      be = BE_WORD;
    end else begin
      case (funct3)
        F3_B:    be = BE_BYTE << addr_lo;
        F3_H:    be = BE_HALF << addr_lo;
        default: be = BE_WORD;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data aligner: shifts the addressed lane down to bit 0
// and sign- or zero-extends it according to the RV32I load width.
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one load/store per START over a single
// outstanding req/ack port. Optional ACK timeout enabled by LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        IS_STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAULT,
  output logic [31:0] RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        fault_q, fault_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_out_q, fault_out_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] load_result;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

  load_aligner u_load_aligner (
    .mem_rdata (MEM_RDATA),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .result    (load_result)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
        if (START) begin
          is_store_d = IS_STORE;
          funct3_d   = FUNCT3;
          addr_lo_d  = ADDR[1:0];
          if (access_fault(IS_STORE, FUNCT3, ADDR[1:0])) begin
            fault_d = 1'b1;
            state_d = FIN;
          end else begin
            fault_d     = 1'b0;
            state_d     = ACCESS;
            mem_addr_d  = {ADDR[31:2], 2'b00};
            mem_wdata_d = store_lanes(FUNCT3, WDATA);
            mem_be_d    = byte_enables(IS_STORE, FUNCT3, ADDR[1:0]);
          end
        end
      end
      ACCESS: begin
        // An ACK arriving on the expiry cycle still completes normally.
        if (MEM_ACK) begin
          if (!is_store_q) begin
            rdata_d = load_result;
          end
          state_d = FIN;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = FIN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    fault_out_d = (state_d == FIN) & fault_d;
    mem_req_d   = (state_d == ACCESS);
    mem_we_d    = (state_d == ACCESS) & is_store_d;
  end

  // NOTE: sequential state uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_out_q <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_out_q <= fault_out_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAULT     = fault_out_q;
  assign RDATA     = rdata_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_BE    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues accesses and queues
// expectations, a memory responder and a DONE monitor check against them.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 4;

  typedef struct {
    bit          fault;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] word;
    int          mode;
  } req_t;

  logic        CLK, RST, START, IS_STORE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, WDATA;
  logic        BUSY, DONE, FAULT;
  logic [31:0] RDATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] model_rdata = 32'h0;
  exp_t        exp_q[$];
  req_t        req_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .IS_STORE  (IS_STORE),
    .FUNCT3    (FUNCT3),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FAULT     (FAULT),
    .RDATA     (RDATA),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_BE    (MEM_BE),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (arithmetic on the RV32I rules) ----------
  function automatic int access_size(input bit [2:0] f3);
    int s;
    case (f3 % 4)
      0:       s = 1;
      1:       s = 2;
      default: s = 4;
    endcase
    return s;
  endfunction

  function automatic bit legal(input bit st, input bit [2:0] f3, input logic [31:0] addr);
    bit ok;
    if (st) ok = (f3 == 0 || f3 == 1 || f3 == 2);
    else    ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return ok && ((addr % access_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] load_value(input bit [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint v, m;
    int     sz;
    sz = access_size(f3);
    v  = longint'(word) / (longint'(1) << (8 * (addr % 4)));
    m  = longint'(1) << (8 * sz);
    v  = v % m;
    if (f3 < 4 && sz < 4 && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  function automatic logic [3:0] store_be(input bit [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = access_size(f3);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] store_data(input bit [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (access_size(f3))
      1:       r = (wd % 256) * 32'h01010101;
      2:       r = (wd % 65536) * 32'h00010001;
      default: r = wd;
    endcase
    return r;
  endfunction

  // ---------------- memory responder ----------------------------------------
  initial begin
    req_t r;
    int   k;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    forever begin
      @(negedge CLK);
      MEM_ACK = 1'b0;
      if (MEM_REQ) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", MEM_REQ, 0);
        end else begin
          r = req_q.pop_front();
          check("mem_we", MEM_WE, r.we);
          check("mem_addr", MEM_ADDR, r.addr);
          check("mem_be", MEM_BE, r.be);
          if (r.we) check("mem_wdata", MEM_WDATA, r.wdata);
          if (r.mode == 0) begin
            repeat (r.dly) @(negedge CLK);
            check("req_held", MEM_REQ, 1);
            check("addr_held", MEM_ADDR, r.addr);
            MEM_ACK   = 1'b1;
            MEM_RDATA = r.word;
          end else if (r.mode == 1) begin
            k = 0;
            while (MEM_REQ && k < 20) begin
              @(negedge CLK);
              k++;
            end
            MEM_ACK   = 1'b1;
            MEM_RDATA = $urandom;
          end else begin
            k = 1;
            @(negedge CLK);
            while (MEM_REQ && k < 20) begin
              k++;
              @(negedge CLK);
            end
            check("timeout_req_cycles", k, TMO);
          end
        end
      end
    end
  end

  // ---------------- completion monitor --------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", DONE, 0);
        end else begin
          e = exp_q.pop_front();
          check("fault", FAULT, e.fault);
          check("rdata", RDATA, e.rdata);
          check("done_cycle", cyc, e.cycle);
          check("busy_at_done", BUSY, 1);
        end
      end
    end
  end

  // ---------------- driver (called at a negedge) ----------------------------
  task automatic issue(input bit st, input bit [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly, input logic [31:0] word,
                       input int mode, input bit poke);
    exp_t e;
    req_t r;
    bit   ok;
    int   n;
    ok = legal(st, f3, addr);
    if (ok && !st && mode == 0) model_rdata = load_value(f3, addr, word);
    e.fault = !ok || (mode == 2);
    e.rdata = model_rdata;
    e.cycle = cyc + 1 + (!ok ? 0 : (mode == 2 ? TMO : dly + 1));
    if (ok) begin
      r.we    = st;
      r.addr  = addr & 32'hFFFF_FFFC;
      r.be    = st ? store_be(f3, addr) : 4'hF;
      r.wdata = store_data(f3, wd);
      r.dly   = dly;
      r.word  = word;
      r.mode  = mode;
      req_q.push_back(r);
    end
    if (mode != 1) exp_q.push_back(e);
    START = 1'b1; IS_STORE = st; FUNCT3 = f3; ADDR = addr; WDATA = wd;
    @(negedge CLK);
    START = 1'b0; IS_STORE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
    check("busy_rise", BUSY, 1);
    if (mode == 1) begin
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_mem_req", MEM_REQ, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      model_rdata = 32'h0;
      repeat (4) @(negedge CLK);
      check("rst_rdata", RDATA, model_rdata);
      return;
    end
    n = 1;
    while (BUSY && n < 40) begin
      if (poke) begin
        START = (n == 1); IS_STORE = 1'b1; FUNCT3 = F3_W; ADDR = 32'h300;
      end
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    if (BUSY) check("busy_timeout", BUSY, 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IS_STORE = 1'b0; FUNCT3 = 3'b000; ADDR = 32'h0; WDATA = 32'h0;
    repeat (3) @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_fault", FAULT, 0);
    check("reset_mem_req", MEM_REQ, 0);
    check("reset_mem_we", MEM_WE, 0);
    check("reset_mem_addr", MEM_ADDR, 0);
    check("reset_mem_wdata", MEM_WDATA, 0);
    check("reset_mem_be", MEM_BE, 0);
    check("reset_rdata", RDATA, 0);
    RST = 1'b0;
    @(negedge CLK);

    issue(1'b0, F3_W,  32'h100, 32'h0,      3, 32'hDEADBEEF, 0, 1'b0);
    issue(1'b0, F3_B,  32'h103, 32'h0,      1, 32'h80FF1234, 0, 1'b0);
    check("lb_sign", RDATA, 32'hFFFFFF80);
    issue(1'b0, F3_BU, 32'h103, 32'h0,      0, 32'h80FF1234, 0, 1'b0);
    check("lbu_zero", RDATA, 32'h00000080);
    issue(1'b1, F3_H,  32'h102, 32'h0000ABCD, 2, 32'h12345678, 0, 1'b0);
    check("sh_keeps_rdata", RDATA, 32'h00000080);
    issue(1'b0, F3_W,  32'h101, 32'h0,      0, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b011, 32'h100, 32'h0,     0, 32'h0, 0, 1'b0);
    issue(1'b1, F3_BU, 32'h100, 32'h0,      0, 32'h0, 0, 1'b0);
    issue(1'b0, F3_HU, 32'h102, 32'h0,      2, 32'h8765CAFE, 0, 1'b1);
    issue(1'b0, F3_H,  32'h102, 32'h0,      0, 32'h0, 1, 1'b0);
`ifdef LSU_TIMEOUT_EN
    issue(1'b0, F3_W,  32'h104, 32'h0,      0, 32'h0, 2, 1'b0);
`endif

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom_range(0, 3), $urandom, 0, ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge CLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle RV32I data-memory access stage between execute and the writeback result mux. Accepts one load or store per START pulse and drives a single-outstanding req/ack data-memory port with byte enables. Aligns and sign/zero-extends load data into RDATA, which feeds the writeback result mux directly. Flags misaligned or illegal-width accesses without touching memory.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles to wait for MEM_ACK (used only with LSU_TIMEOUT_EN); 1..255
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin access; sampled only in IDLE
- IS_STORE  in  1  1 = store, 0 = load
- FUNCT3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDR  in  32  byte address (rs1+imm)
- WDATA  in  32  store data (rs2)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- FAULT  out  1  valid with DONE: misaligned, illegal FUNCT3, or timeout
- RDATA  out  32  aligned, extended load result; holds until the next load DONE
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  write enable
- MEM_ADDR  out  32  word address, {ADDR[31:2],2'b00}
- MEM_WDATA  out  32  lane-replicated store data
- MEM_BE  out  4  byte enables
- MEM_RDATA  in  32  read word, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion from memory

## Operation
- States: IDLE, ACCESS, FIN.
- IDLE: on START, latch IS_STORE, FUNCT3, ADDR, WDATA.
  - Illegal FUNCT3 (load 011/110/111; store 1xx or 011) or misaligned (H with ADDR[0]=1; W with ADDR[1:0]≠0): go to FIN with fault set. No MEM_REQ.
  - Otherwise go to ACCESS.
- ACCESS: MEM_REQ=1. MEM_WE/ADDR/WDATA/BE stay stable until MEM_ACK. On MEM_ACK, loads capture the extracted result, then go to FIN.
- FIN: DONE=1, FAULT=fault flag, then go to IDLE.
- Store lanes:
  - SB: WDATA={4{WDATA[7:0]}}, BE=4'b0001<<ADDR[1:0]
  - SH: WDATA={2{WDATA[15:0]}}, BE=4'b0011<<ADDR[1:0]
  - SW: WDATA=WDATA, BE=4'b1111
- Load extract: shift MEM_RDATA right by 8*ADDR[1:0]. Then LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW passes through. Loads drive MEM_BE=4'b1111.
- Faulted loads and all stores leave RDATA unchanged.
- START while BUSY is ignored. MEM_ACK outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; BUSY, DONE, FAULT, MEM_REQ, MEM_WE = 0; MEM_ADDR, MEM_WDATA, RDATA = 0; MEM_BE = 4'b0000.
- START in cycle 0, MEM_REQ from cycle 1. With MEM_ACK in cycle k≥1, DONE is high in cycle k+1. Minimum latency is 2 cycles.
- A fault path gives DONE in cycle 1.
- BUSY rises in cycle 1 and falls in the cycle after DONE. A new START is accepted in the cycle after DONE.
- RST mid-access: MEM_REQ is low after that edge. A late MEM_ACK is ignored and no DONE is issued.
- All outputs are registered.

## Configuration
- LSU_TIMEOUT_EN defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without MEM_ACK. At TIMEOUT_CYCLES it drops MEM_REQ and goes to FIN with FAULT=1. MEM_ACK in the same cycle as expiry wins, and completion is normal.
- LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package lsu_pkg holds:
  - FUNCT3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, ACCESS, FIN)
  - base byte-enable constants
- Sub-module load_aligner: combinational (MEM_RDATA, addr_lo[1:0], funct3) -> 32-bit result. Instantiated once.

## Test plan
- LW at ADDR=0x100, MEM_RDATA=0xDEADBEEF, ACK 3 cycles after REQ -> MEM_ADDR=0x100, BE=1111, DONE one cycle after ACK, RDATA=0xDEADBEEF, FAULT=0.
- LB at 0x103 with 0x80FF1234; then LBU at 0x103 with the same word -> RDATA=0xFFFFFF80, then 0x00000080.
- SH at 0x102, WDATA=0x0000ABCD -> MEM_WE=1, BE=1100, MEM_WDATA=0xABCDABCD, RDATA unchanged.
- LW at 0x101 -> no MEM_REQ, DONE and FAULT in cycle 1; FUNCT3=011 load -> same response.
- RST asserted in ACCESS, then MEM_ACK the next cycle -> MEM_REQ=0, no DONE, BUSY=0; START asserted during BUSY ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK -> MEM_REQ drops after 4 ACCESS cycles, then DONE=1 and FAULT=1.
